// File: rtl/fcpu_pkg.sv
// fcpu_pkg -- shared types and constants for the commit stage.
//   DATA_W / REG_ADDR_W / RSV_ID_W / OPC_W : datapath, register-address,
//                                            station-id and opcode widths
//   OPC_*          : opcode encodings seen at the ROB head
//   commit_state_t : commit FSM state encoding
//   station_t      : ROB head entry presented to the commit unit
//   branch_target  : redirect address recovered from a branch entry's content
package fcpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int RSV_ID_W   = 4;
  localparam int OPC_W      = 4;

  localparam logic [OPC_W-1:0] OPC_ALU    = 4'd0;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 4'd1;
  localparam logic [OPC_W-1:0] OPC_STORE  = 4'd2;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 4'd3;
  localparam logic [OPC_W-1:0] OPC_HALT   = 4'd4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2,
    HALT       = 2'd3
  } commit_state_t;

  typedef struct packed {
    logic [RSV_ID_W-1:0]   station_id;
    logic                  valid;
    logic                  ready;
    logic [REG_ADDR_W-1:0] dst_reg;
    logic [OPC_W-1:0]      opcode;
    logic [DATA_W-1:0]     content;
  } station_t;

  // A branch entry carries its resolved target with bit 0 reused as the
  // mispredict flag, so the target is the content with bit 0 cleared.
  function automatic logic [DATA_W-1:0] branch_target(input logic [DATA_W-1:0] c);
    return {c[DATA_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/commit_unit.sv
// commit_unit -- retires the ROB head entry.
//   clk, rst                 : clock, synchronous active-high reset
//   i_valid / i_ready        : commit handshake with the ROB head
//   i_commit_data            : head entry (station_t)
//   rf_we/rf_addr/rf_data/rf_rsv_id : registered architectural register write
//   st_valid/st_rsv_id/st_ready     : store release handshake to store buffer
//   clear/redirect_valid/redirect_pc: one-cycle mispredict flush and redirect
//   o_halted                 : high while halted (left only via rst)
// Optional feature macro COMMIT_PERF_EN adds 64-bit counters o_instret
// (accepts) and o_stall_cycles (cycles with i_valid high and i_ready low).
module commit_unit
  import fcpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  station_t              i_commit_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0]     rf_data,
  output logic [RSV_ID_W-1:0]   rf_rsv_id,
  output logic                  st_valid,
  output logic [RSV_ID_W-1:0]   st_rsv_id,
  input  logic                  st_ready,
  output logic                  clear,
  output logic                  redirect_valid,
  output logic [DATA_W-1:0]     redirect_pc,
`ifdef COMMIT_PERF_EN
  output logic [63:0]           o_instret,
  output logic [63:0]           o_stall_cycles,
`endif
  output logic                  o_halted
);

  commit_state_t state_p0, state_nxt;

  logic accept;
  logic is_store, is_halt, is_branch, mispredict, do_wr;

  logic                  rf_we_p1;
  logic [REG_ADDR_W-1:0] rf_addr_p1;
  logic [DATA_W-1:0]     rf_data_p1;
  logic [RSV_ID_W-1:0]   rf_rsv_id_p1;
  logic [RSV_ID_W-1:0]   st_rsv_id_p1;
  logic [DATA_W-1:0]     redirect_pc_p1;

  // The entry's own valid/ready flags are not used for commit decisions.
  logic unused_entry_flags;
  assign unused_entry_flags = ^{i_commit_data.valid, i_commit_data.ready};

  // Entry decode (only meaningful when accept is high)
  assign is_store   = (i_commit_data.opcode == OPC_STORE);
  assign is_halt    = (i_commit_data.opcode == OPC_HALT);
  assign is_branch  = (i_commit_data.opcode == OPC_BRANCH);
  assign mispredict = is_branch & i_commit_data.content[0];
  // A mispredicted branch still writes its link register, if any.
  assign do_wr      = accept & ~is_store & ~is_halt & (i_commit_data.dst_reg != '0);

  always_comb begin
    state_nxt      = state_p0;
    accept         = 1'b0;
    i_ready        = 1'b0;
    st_valid       = 1'b0;
    clear          = 1'b0;
    redirect_valid = 1'b0;
    o_halted       = 1'b0;
    case (state_p0)
      IDLE: begin
        i_ready = 1'b1;
        accept  = i_valid;
        if (accept) begin
          if (is_store)        state_nxt = STORE_WAIT;
          else if (is_halt)    state_nxt = HALT;
          else if (mispredict) state_nxt = FLUSH;
        end
      end
      STORE_WAIT: begin
        st_valid = 1'b1;
        if (st_ready) state_nxt = IDLE;
      end
      FLUSH: begin
        clear          = 1'b1;
        redirect_valid = 1'b1;
        state_nxt      = IDLE;
      end
      HALT: begin
        o_halted = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0 -> p1: state and registered commit outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0       <= IDLE;
      rf_we_p1       <= 1'b0;
      rf_addr_p1     <= '0;
      rf_data_p1     <= '0;
      rf_rsv_id_p1   <= '0;
      st_rsv_id_p1   <= '0;
      redirect_pc_p1 <= '0;
    end else begin
      state_p0 <= state_nxt;
      rf_we_p1 <= do_wr;
      if (do_wr) begin
        rf_addr_p1   <= i_commit_data.dst_reg;
        rf_data_p1   <= i_commit_data.content;
        rf_rsv_id_p1 <= i_commit_data.station_id;
      end
      if (accept & is_store)
        st_rsv_id_p1 <= i_commit_data.station_id;
      if (accept & mispredict)
        redirect_pc_p1 <= branch_target(i_commit_data.content);
    end
  end

  assign rf_we       = rf_we_p1;
  assign rf_addr     = rf_addr_p1;
  assign rf_data     = rf_data_p1;
  assign rf_rsv_id   = rf_rsv_id_p1;
  assign st_rsv_id   = st_rsv_id_p1;
  assign redirect_pc = redirect_pc_p1;

`ifdef COMMIT_PERF_EN
  logic [63:0] instret_p1;
  logic [63:0] stall_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_p1 <= '0;
      stall_p1   <= '0;
    end else begin
      if (accept)              instret_p1 <= instret_p1 + 64'd1;
      if (i_valid & ~i_ready)  stall_p1   <= stall_p1 + 64'd1;
    end
  end

  assign o_instret      = instret_p1;
  assign o_stall_cycles = stall_p1;
`endif

endmodule

// File: tb/tb_commit_unit.sv
module tb_commit_unit;
  import fcpu_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  i_valid;
  logic                  i_ready;
  station_t              i_commit_data;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0]     rf_data;
  logic [RSV_ID_W-1:0]   rf_rsv_id;
  logic                  st_valid;
  logic [RSV_ID_W-1:0]   st_rsv_id;
  logic                  st_ready;
  logic                  clear;
  logic                  redirect_valid;
  logic [DATA_W-1:0]     redirect_pc;
  logic                  o_halted;
`ifdef COMMIT_PERF_EN
  logic [63:0]           o_instret;
  logic [63:0]           o_stall_cycles;
`endif

  commit_unit dut (
    .clk            (clk),
    .rst            (rst),
    .i_valid        (i_valid),
    .i_ready        (i_ready),
    .i_commit_data  (i_commit_data),
    .rf_we          (rf_we),
    .rf_addr        (rf_addr),
    .rf_data        (rf_data),
    .rf_rsv_id      (rf_rsv_id),
    .st_valid       (st_valid),
    .st_rsv_id      (st_rsv_id),
    .st_ready       (st_ready),
    .clear          (clear),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef COMMIT_PERF_EN
    .o_instret      (o_instret),
    .o_stall_cycles (o_stall_cycles),
`endif
    .o_halted       (o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: what the commit stage has promised, in plain terms.
  bit          m_halted, m_store_pending, m_flush_pending;
  bit          m_rf_we;
  logic [63:0] m_rf_addr, m_rf_data, m_rf_id, m_st_id, m_pc;
  longint unsigned m_instret, m_stall;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_store_pending = 0; m_flush_pending = 0;
    m_rf_we = 0; m_rf_addr = 0; m_rf_data = 0; m_rf_id = 0;
    m_st_id = 0; m_pc = 0; m_instret = 0; m_stall = 0;
  endtask

  // Advance one clock: update the model from the inputs presented this
  // cycle, then compare every DUT output just after the edge.
  task automatic tick();
    bit can_take;
    can_take = !(m_halted || m_store_pending || m_flush_pending);
    if (rst) begin
      model_reset();
    end else begin
      if (i_valid && !can_take) m_stall++;
      m_rf_we = 0;
      m_flush_pending = 0;
      if (m_store_pending && st_ready) m_store_pending = 0;
      if (i_valid && can_take) begin
        m_instret++;
        if (i_commit_data.opcode == OPC_STORE) begin
          m_store_pending = 1;
          m_st_id = 64'(i_commit_data.station_id);
        end else if (i_commit_data.opcode == OPC_HALT) begin
          m_halted = 1;
        end else begin
          if (i_commit_data.dst_reg != 0) begin
            m_rf_we   = 1;
            m_rf_addr = 64'(i_commit_data.dst_reg);
            m_rf_data = 64'(i_commit_data.content);
            m_rf_id   = 64'(i_commit_data.station_id);
          end
          if (i_commit_data.opcode == OPC_BRANCH && i_commit_data.content[0]) begin
            m_flush_pending = 1;
            m_pc = 64'(i_commit_data.content) & ~64'd1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    chk("i_ready",        64'(i_ready),        64'(!(m_halted || m_store_pending || m_flush_pending)));
    chk("rf_we",          64'(rf_we),          64'(m_rf_we));
    chk("rf_addr",        64'(rf_addr),        m_rf_addr);
    chk("rf_data",        64'(rf_data),        m_rf_data);
    chk("rf_rsv_id",      64'(rf_rsv_id),      m_rf_id);
    chk("st_valid",       64'(st_valid),       64'(m_store_pending));
    chk("st_rsv_id",      64'(st_rsv_id),      m_st_id);
    chk("clear",          64'(clear),          64'(m_flush_pending));
    chk("redirect_valid", 64'(redirect_valid), 64'(m_flush_pending));
    chk("redirect_pc",    64'(redirect_pc),    m_pc);
    chk("o_halted",       64'(o_halted),       64'(m_halted));
`ifdef COMMIT_PERF_EN
    chk("o_instret",      o_instret,           m_instret);
    chk("o_stall_cycles", o_stall_cycles,      m_stall);
`endif
  endtask

  task automatic drive(input logic v, input logic [OPC_W-1:0] opc, input logic [REG_ADDR_W-1:0] dst,
                       input logic [DATA_W-1:0] cont, input logic [RSV_ID_W-1:0] id);
    i_valid                  = v;
    i_commit_data.opcode     = opc;
    i_commit_data.dst_reg    = dst;
    i_commit_data.content    = cont;
    i_commit_data.station_id = id;
    i_commit_data.valid      = v;
    i_commit_data.ready      = 1'b1;
  endtask

  initial begin
    int sv_cnt;
    logic [OPC_W-1:0] opc;
    int r;

    rst = 1'b1;
    st_ready = 1'b0;
    drive(1'b0, OPC_ALU, '0, '0, '0);
    model_reset();

    // Reset state
    tick();
    tick();
    chk("rst_i_ready", 64'(i_ready), 64'd1);
    chk("rst_rf_we",   64'(rf_we),   64'd0);
    rst = 1'b0;
    tick();

    // ALU commit
    drive(1'b1, OPC_ALU, 5'd5, 32'h1234, 4'd3);
    tick();
    chk("alu_rf_we",     64'(rf_we),     64'd1);
    chk("alu_rf_addr",   64'(rf_addr),   64'd5);
    chk("alu_rf_data",   64'(rf_data),   64'h1234);
    chk("alu_rf_rsv_id", 64'(rf_rsv_id), 64'd3);
    chk("alu_i_ready",   64'(i_ready),   64'd1);
    drive(1'b1, OPC_LOAD, 5'd0, 32'hdead, 4'd2);
    tick();
    chk("r0_no_write", 64'(rf_we), 64'd0);
    drive(1'b0, OPC_ALU, '0, '0, '0);
    tick();

    // Store held off for 4 cycles; i_valid stays high with other work
    st_ready = 1'b0;
    drive(1'b1, OPC_STORE, 5'd9, 32'h55, 4'd7);
    tick();
    sv_cnt = int'(st_valid);
    chk("st_rsv_id", 64'(st_rsv_id), 64'd7);
    drive(1'b1, OPC_ALU, 5'd4, 32'h77, 4'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      sv_cnt += int'(st_valid);
      chk("st_wait_i_ready", 64'(i_ready), 64'd0);
      chk("st_wait_rf_we",   64'(rf_we),   64'd0);
      chk("st_hold_id",      64'(st_rsv_id), 64'd7);
    end
    st_ready = 1'b1;
    drive(1'b0, OPC_ALU, '0, '0, '0);
    tick();
    sv_cnt += int'(st_valid);
    chk("st_valid_cycles", 64'(sv_cnt), 64'd5);
    chk("st_done_ready",   64'(i_ready), 64'd1);

    // Back-to-back stores with st_ready held high
    drive(1'b1, OPC_STORE, 5'd0, 32'h1, 4'd8);
    tick();
    tick();
    tick();
    drive(1'b0, OPC_ALU, '0, '0, '0);
    tick();

    // Mispredicted branch with link register
    drive(1'b1, OPC_BRANCH, 5'd1, 32'h1001, 4'd6);
    tick();
    chk("br_rf_we",       64'(rf_we),          64'd1);
    chk("br_rf_addr",     64'(rf_addr),        64'd1);
    chk("br_clear",       64'(clear),          64'd1);
    chk("br_redirect",    64'(redirect_valid), 64'd1);
    chk("br_redirect_pc", 64'(redirect_pc),    64'h1000);
    drive(1'b0, OPC_ALU, '0, '0, '0);
    tick();
    chk("br_clear_once",  64'(clear),          64'd0);

    // Correctly predicted branch: no flush
    drive(1'b1, OPC_BRANCH, 5'd2, 32'h2000, 4'd5);
    tick();
    chk("br_ok_clear", 64'(clear), 64'd0);
    drive(1'b0, OPC_ALU, '0, '0, '0);
    tick();

    // HALT, then more requests are ignored
    drive(1'b1, OPC_HALT, 5'd3, 32'h9, 4'd4);
    tick();
    drive(1'b1, OPC_ALU, 5'd3, 32'h99, 4'd4);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("halt_o_halted", 64'(o_halted), 64'd1);
      chk("halt_i_ready",  64'(i_ready),  64'd0);
    end
    rst = 1'b1;
    drive(1'b0, OPC_ALU, '0, '0, '0);
    tick();
    rst = 1'b0;
    chk("halt_rst_ready", 64'(i_ready), 64'd1);

    // Reset during STORE_WAIT
    st_ready = 1'b0;
    drive(1'b1, OPC_STORE, 5'd0, 32'h3, 4'd2);
    tick();
    drive(1'b0, OPC_ALU, '0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_st_valid", 64'(st_valid), 64'd0);
    chk("rst_ready",    64'(i_ready),  64'd1);
`ifdef COMMIT_PERF_EN
    chk("rst_instret",  o_instret,     64'd0);
`endif
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3)       opc = OPC_HALT;
      else if (r < 25) opc = OPC_STORE;
      else if (r < 45) opc = OPC_BRANCH;
      else if (r < 70) opc = OPC_LOAD;
      else             opc = OPC_ALU;
      drive(1'($urandom_range(0, 3) != 0), opc,
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            32'($urandom), 4'($urandom));
      st_ready = 1'($urandom_range(0, 1));
      rst      = ($urandom_range(0, 99) < 2) || (m_halted && $urandom_range(0, 9) == 0);
      tick();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
